// File: rtl/butterfly8_out_serializer_if.sv
// Frame-in / beat-out handshake bundle for the butterfly output serializer.
// The upstream/consumer side uses master; the serializer uses slave.
interface butterfly8_out_serializer_if #(
  parameter int NPTS  = 8,
  parameter int IN_W  = 64,
  parameter int OUT_W = 32
);
  localparam int IDX_W = $clog2(NPTS);

  logic                   in_valid;
  logic                   in_ready;
  logic [NPTS*IN_W-1:0]   in_real;
  logic [NPTS*IN_W-1:0]   in_im;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_real;
  logic [OUT_W-1:0]       out_im;
  logic [IDX_W-1:0]       out_idx;
  logic                   out_last;
  logic                   out_sat;

  modport master (
    output in_valid, in_real, in_im, out_ready,
    input  in_ready, out_valid, out_real, out_im, out_idx, out_last, out_sat
  );

  modport slave (
    input  in_valid, in_real, in_im, out_ready,
    output in_ready, out_valid, out_real, out_im, out_idx, out_last, out_sat
  );
endinterface

// File: rtl/butterfly8_out_serializer.sv
// Captures one NPTS-lane complex frame, removes the Q7 gain with round-half-up,
// saturates to OUT_W and streams the lanes out one beat at a time.
module butterfly8_out_serializer #(
  parameter int NPTS  = 8,
  parameter int IN_W  = 64,
  parameter int OUT_W = 32,
  parameter int SHIFT = 7
) (
  input  logic                           clk,
  input  logic                           rst_n,
  butterfly8_out_serializer_if.slave     bus,
  output logic [15:0]                    frame_cnt
);
  localparam int IDX_W = $clog2(NPTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);
  localparam logic signed [IN_W:0] RND  = (IN_W + 1)'((2 ** SHIFT) / 2);
  localparam logic signed [IN_W:0] MAXV = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state, state_next;
  logic [IDX_W-1:0]        idx;
  logic signed [OUT_W-1:0] buf_re [NPTS];
  logic signed [OUT_W-1:0] buf_im [NPTS];
  logic [NPTS-1:0]         buf_sat;
  logic signed [OUT_W-1:0] cap_re [NPTS];
  logic signed [OUT_W-1:0] cap_im [NPTS];
  logic [NPTS-1:0]         cap_sat;
  logic                    fire, last_fire, accept;

  // Returns {clip, value}; the extra MSB keeps x + RND from overflowing.
  function automatic logic [OUT_W:0] scale(input logic [IN_W-1:0] x);
    logic signed [IN_W:0] t;
    logic signed [IN_W:0] y;
    t = $signed({x[IN_W-1], x}) + RND;
    y = t >>> SHIFT;
    if (y > MAXV) return {1'b1, MAXV[OUT_W-1:0]};
    if (y < MINV) return {1'b1, MINV[OUT_W-1:0]};
    return {1'b0, y[OUT_W-1:0]};
  endfunction

  always_comb begin
    logic [OUT_W:0] r;
    logic [OUT_W:0] i;
    r       = '0;
    i       = '0;
    cap_sat = '0;
    for (int unsigned k = 0; k < NPTS; k++) begin
      r          = scale(bus.in_real[k*IN_W +: IN_W]);
      i          = scale(bus.in_im[k*IN_W +: IN_W]);
      cap_re[k]  = r[OUT_W-1:0];
      cap_im[k]  = i[OUT_W-1:0];
      cap_sat[k] = r[OUT_W] | i[OUT_W];
    end
  end

  assign bus.out_valid = (state == SEND);
  assign bus.out_idx   = idx;
  assign bus.out_last  = (state == SEND) && (idx == LAST_IDX);
  assign bus.out_real  = buf_re[idx];
  assign bus.out_im    = buf_im[idx];
  assign bus.out_sat   = buf_sat[idx];

  assign fire      = bus.out_valid && bus.out_ready;
  assign last_fire = fire && bus.out_last;
  // The last-beat term lets a waiting frame load with no bubble; rst_n holds ready low during reset.
  assign bus.in_ready = rst_n && ((state == IDLE) || last_fire);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SEND;
      SEND:    if (last_fire) state_next = accept ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      frame_cnt <= '0;
      buf_sat   <= '0;
      for (int unsigned k = 0; k < NPTS; k++) begin
        buf_re[k] <= '0;
        buf_im[k] <= '0;
      end
    end else begin
      if (last_fire) frame_cnt <= frame_cnt + 16'd1;
      if (accept) begin
        idx     <= '0;
        buf_sat <= cap_sat;
        for (int unsigned k = 0; k < NPTS; k++) begin
          buf_re[k] <= cap_re[k];
          buf_im[k] <= cap_im[k];
        end
      end else if (last_fire) begin
        idx <= '0;
      end else if (fire) begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_butterfly8_out_serializer.sv
// Scoreboard bench: accepted frames push expected beats from a floor-division
// reference model; a monitor pops and compares on every output handshake.
module tb_butterfly8_out_serializer;
  localparam int NPTS  = 8;
  localparam int IN_W  = 64;
  localparam int OUT_W = 32;
  localparam int SHIFT = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  butterfly8_out_serializer_if #(.NPTS(NPTS), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  butterfly8_out_serializer #(.NPTS(NPTS), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    logic [OUT_W-1:0] re;
    logic [OUT_W-1:0] im;
    int unsigned      idx;
    bit               last;
    bit               sat;
  } beat_t;

  typedef struct {
    logic             valid;
    logic [OUT_W-1:0] re;
    logic [OUT_W-1:0] im;
    logic [2:0]       idx;
    logic             last;
    logic             sat;
  } snap_t;

  beat_t              exp_q[$];
  int unsigned        fire_cyc[$];
  int                 total = 0;
  int                 bad = 0;
  logic [15:0]        exp_frames = '0;
  int unsigned        cyc = 0;
  int                 rmode = 0;
  logic signed [IN_W-1:0] fre [NPTS];
  logic signed [IN_W-1:0] fim [NPTS];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Round half up = floor((x + 2^(S-1)) / 2^S), then clip to the OUT_W range.
  function automatic void ref_scale(input logic signed [IN_W-1:0] x,
                                    output logic [OUT_W-1:0] y, output bit clip);
    logic signed [127:0] t, q, d, hi, lo;
    d = 128'sd1 <<< SHIFT;
    t = x;
    if (SHIFT > 0) t = t + d / 2;
    q = t / d;
    if (t < 0 && q * d != t) q = q - 1;
    hi = (128'sd1 <<< (OUT_W - 1)) - 1;
    lo = -(128'sd1 <<< (OUT_W - 1));
    clip = 1'b0;
    if (q > hi) begin q = hi; clip = 1'b1; end
    else if (q < lo) begin q = lo; clip = 1'b1; end
    y = q[OUT_W-1:0];
  endfunction

  function automatic logic signed [IN_W-1:0] rnd_comp();
    logic signed [IN_W-1:0] v;
    case ($urandom_range(0, 3))
      0: begin v = 64'($urandom_range(0, 4000)); v = v - 2000; end
      1: begin v = 64'($urandom_range(0, 2000)); v = (v - 1000) * 128 + 64; end
      2: v = {$urandom, $urandom};
      default: begin v = 64'(signed'($urandom)); v = v <<< 8; end
    endcase
    return v;
  endfunction

  task automatic clear_frame();
    for (int k = 0; k < NPTS; k++) begin fre[k] = '0; fim[k] = '0; end
  endtask

  task automatic random_frame();
    for (int k = 0; k < NPTS; k++) begin fre[k] = rnd_comp(); fim[k] = rnd_comp(); end
  endtask

  task automatic push_expected();
    beat_t b;
    bit cr, ci;
    for (int k = 0; k < NPTS; k++) begin
      ref_scale(fre[k], b.re, cr);
      ref_scale(fim[k], b.im, ci);
      b.idx  = k;
      b.last = (k == NPTS - 1);
      b.sat  = cr | ci;
      exp_q.push_back(b);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_frame();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < NPTS; k++) begin
      bus.in_real[k*IN_W +: IN_W] = fre[k];
      bus.in_im[k*IN_W +: IN_W]   = fim[k];
    end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    else     push_expected();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_real  = {NPTS{$urandom, $urandom}};
    bus.in_im    = {NPTS{$urandom, $urandom}};
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    chk({name, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
    chk({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  // out_ready driver: 0 = always, 1 = pattern 1,0,0, 2 = random
  initial begin
    int unsigned pat;
    pat = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       begin bus.out_ready = (pat % 3 == 0); pat++; end
        default: bus.out_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor
  initial begin
    snap_t prev;
    bit    stalled;
    beat_t e;
    stalled = 1'b0;
    prev = '{default: '0};
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 64'(bus.out_valid), 64'(prev.valid));
          chk("stall_real", 64'(bus.out_real), 64'(prev.re));
          chk("stall_im", 64'(bus.out_im), 64'(prev.im));
          chk("stall_idx", 64'(bus.out_idx), 64'(prev.idx));
          chk("stall_last_sat", 64'({bus.out_last, bus.out_sat}), 64'({prev.last, prev.sat}));
        end
        if (bus.out_valid) begin
          chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
          if (bus.out_ready) begin
            fire_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
              chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
              e = exp_q.pop_front();
              chk("beat_real", 64'(bus.out_real), 64'(e.re));
              chk("beat_im", 64'(bus.out_im), 64'(e.im));
              chk("beat_idx", 64'(bus.out_idx), 64'(e.idx));
              chk("beat_last", 64'(bus.out_last), 64'(e.last));
              chk("beat_sat", 64'(bus.out_sat), 64'(e.sat));
              if (!e.last) chk("in_ready_midframe", 64'(bus.in_ready), 64'd0);
              if (e.last) exp_frames = exp_frames + 16'd1;
            end
          end else begin
            chk("in_ready_stalled", 64'(bus.in_ready), 64'd0);
          end
        end
        stalled    = bus.out_valid && !bus.out_ready;
        prev.valid = bus.out_valid;
        prev.re    = bus.out_real;
        prev.im    = bus.out_im;
        prev.idx   = bus.out_idx;
        prev.last  = bus.out_last;
        prev.sat   = bus.out_sat;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0;
    bit ok;
    bus.in_valid = 1'b0;
    bus.in_real  = '0;
    bus.in_im    = '0;
    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_out_idx", 64'(bus.out_idx), 64'd0);
    chk("rst_out_data", 64'({bus.out_real, bus.out_im}), 64'd0);
    chk("rst_out_sat", 64'(bus.out_sat), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single impulse on lane a
    rmode = 0;
    clear_frame();
    fre[0] = 640; fim[0] = -640;
    fire_cyc.delete();
    send_frame();
    drain();
    chk("t1_beats", 64'(fire_cyc.size()), 64'd8);
    if (fire_cyc.size() == 8) chk("t1_consecutive", 64'(fire_cyc[7] - fire_cyc[0]), 64'd7);
    check_idle("t1");

    // 2: rounding, 3: saturation
    clear_frame();
    fre[1] = 192; fim[1] = -192;
    fre[2] = 64;  fim[2] = -65;
    fre[3] = 64'sd1 <<< 40; fim[3] = -(64'sd1 <<< 40);
    fre[4] = 64'sd2147483647 * 128;
    fre[5] = 64'sd2147483648 * 128 - 64; fim[5] = -(64'sd2147483648 * 128) - 65;
    send_frame();
    drain();
    check_idle("t23");

    // 4: backpressure
    rmode = 1;
    random_frame();
    send_frame();
    drain();
    check_idle("t4");

    // 5: back-to-back
    rmode = 0;
    fire_cyc.delete();
    random_frame();
    send_frame();
    random_frame();
    send_frame();
    drain();
    chk("t5_beats", 64'(fire_cyc.size()), 64'd16);
    if (fire_cyc.size() == 16) chk("t5_no_gap", 64'(fire_cyc[15] - fire_cyc[0]), 64'd15);
    check_idle("t5");

    // Random traffic with random backpressure and occasional back-to-back
    rmode = 2;
    for (int f = 0; f < 12; f++) begin
      random_frame();
      send_frame();
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();
    check_idle("rnd");

    // 6: reset mid-frame
    rmode = 0;
    random_frame();
    n0 = fire_cyc.size();
    send_frame();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fire_cyc.size() >= n0 + 4) begin ok = 1'b1; break; end
    end
    chk("t6_reach_beat3", 64'(ok), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("t6_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t6_out_data", 64'({bus.out_real, bus.out_im}), 64'd0);
    exp_q.delete();
    exp_frames = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready_after", 64'(bus.in_ready), 64'd1);
    chk("t6_idx_after", 64'(bus.out_idx), 64'd0);
    @(posedge clk); #1;
    random_frame();
    send_frame();
    drain();
    check_idle("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/butterfly8_out_serializer.md
Name: butterfly8_out_serializer

Overview:
- Downstream neighbour of the 8-point radix-2 butterfly stage (lanes a..h, Q7 twiddles, outputs scaled by 128).
- Captures one 8-lane complex result frame through a valid/ready handshake.
- Removes the Q7 gain with round-half-up, saturates each component to OUT_W, and streams the 8 complex samples out one per beat, in lane order, under valid/ready.

Parameters:
- NPTS, 8, complex lanes per frame (power of two, ≥2).
- IN_W, 64, signed input component width.
- OUT_W, 32, signed output component width (OUT_W ≤ IN_W).
- SHIFT, 7, right-shift that removes the twiddle gain (0 = no shift, no rounding).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  frame present on in_real/in_im.
- in_ready  out  1  frame accepted when in_valid && in_ready.
- in_real  in  NPTS*IN_W  lane k real at [k*IN_W +: IN_W]; lane 0 = a ... lane 7 = h.
- in_im  in  NPTS*IN_W  lane k imaginary, same packing.
- out_valid  out  1  beat present.
- out_ready  in  1  beat consumed when out_valid && out_ready.
- out_real  out  OUT_W  scaled, saturated real component.
- out_im  out  OUT_W  scaled, saturated imaginary component.
- out_idx  out  log2(NPTS)  lane index of the current beat.
- out_last  out  1  high on the beat where out_idx == NPTS-1.
- out_sat  out  1  real or imaginary component of this beat was clipped.
- frame_cnt  out  16  frames fully emitted; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; out_valid=0; out_idx=0; frame_cnt=0.
  - out_real, out_im and out_sat all 0; in_ready=0 while rst_n is low.
  - Any partially sent frame is discarded.
- FSM IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: register all 2*NPTS processed components into the buffer, set idx=0, go to SEND.
  - out_valid rises the cycle after acceptance (1-cycle latency).
- FSM SEND:
  - out_valid=1; outputs are driven from buffer[idx].
  - On out_ready with idx<NPTS-1: idx increments.
  - On out_ready with idx==NPTS-1 (last beat):
    - frame_cnt increments.
    - If in_valid is also high, accept the new frame the same cycle, reload the buffer, set idx=0 and stay in SEND. This gives zero bubble between frames.
    - Otherwise go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is a combinational path from out_ready.
- Without out_ready, all out_* signals hold stable and in_ready=0.
- Arithmetic, per component x (done at capture):
  - t = x + 2^(SHIFT-1), computed in IN_W+1 bits so there is no overflow. Skip the add when SHIFT=0.
  - y = t >>> SHIFT (arithmetic). This rounds half toward +inf: 1.5 -> 2, -1.5 -> -1.
  - If y > 2^(OUT_W-1)-1, clamp to the max. If y < -2^(OUT_W-1), clamp to the min.
  - out_sat for the beat = OR of the real and imaginary clip flags, stored per lane in the buffer.
- Inputs are sampled only on the accept edge; they may change freely at other times.
- frame_cnt increments only when a last beat completes, never on acceptance.

Test Plan:
1. Lane a real=640, im=-640, all other lanes 0, out_ready=1 -> 8 beats on 8 consecutive cycles; beat0 = (5,-5), beats 1..7 = (0,0); out_last only on beat 7; frame_cnt=1.
2. Rounding: lane b real=192, im=-192; lane c real=64, im=-65 -> beat1 = (2,-1), beat2 = (1,-1); out_sat=0.
3. Saturation: lane d real=2^40, im=-2^40 -> beat3 = (0x7FFFFFFF, 0x80000000), out_sat=1; beat with lane e real=(2^31-1)*128 -> 0x7FFFFFFF, out_sat=0.
4. Backpressure: out_ready toggles 1,0,0,1,... -> each beat held stable while stalled; beat order 0..7 preserved; in_ready stays 0 until the last-beat handshake.
5. Back-to-back: in_valid held with two frames, out_ready=1 -> 16 beats with no gap, second frame accepted on the cycle of the first frame's out_last; frame_cnt=2.
6. Reset mid-frame: drop rst_n after beat 3 -> out_valid=0 and frame_cnt=0 immediately. After release, in_ready=1 and a new frame restarts at out_idx=0.
